pipe_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Merges stall requests from the IF/ID/EX/MEM stages into the 6-bit stall vector consumed by the PC register and the stage registers.
- Sequences exception/ERET redirects: freeze, then a one-cycle flush, then restart at a new PC.
- Watches for pipelines stuck in stall.

---
 rtl/pipe_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline stall merge, exception redirect sequencer and stall watchdog
// Optional perf_stall_cnt output when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter logic [31:0] ERET_CODE     = 32'h0000000e,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        stall_timeout
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FREEZE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    localparam logic [15:0] TO_LIMIT = 16'(STALL_TIMEOUT - 1);

    logic [1:0]  state;
    logic [31:0] new_pc_reg;
    logic [15:0] stall_run;
    logic        exc_take;

    assign exc_take = (state == S_RUN) && (excepttype_i != 32'd0);

    // An exception in RUN overrides every stage request with the freeze vector.
    always_comb begin
        stall = 6'b000000;
        case (state)
            S_RUN: begin
                if (exc_take)          stall = 6'b011111;
                else if (stallreq_mem) stall = 6'b011111;
                else if (stallreq_ex)  stall = 6'b001111;
                else if (stallreq_id)  stall = 6'b000111;
                else if (stallreq_if)  stall = 6'b000111;
                else                   stall = 6'b000000;
            end
            S_FREEZE: stall = 6'b011111;
            default:  stall = 6'b000000;
        endcase
    end

    assign flush  = (state == S_FLUSH);
    assign new_pc = new_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            new_pc_reg <= 32'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (exc_take) begin
                        state      <= S_FREEZE;
                        new_pc_reg <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                S_FREEZE: state <= S_FLUSH;
                default:  state <= S_RUN;
            endcase
        end
    end

    // Leaving FREEZE is the entry into FLUSH, so the run length restarts there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run     <= 16'd0;
            stall_timeout <= 1'b0;
        end else begin
            if (state == S_FREEZE)
                stall_run <= 16'd0;
            else if (stall[0]) begin
                if (stall_run != 16'hFFFF)
                    stall_run <= stall_run + 16'd1;
            end else
                stall_run <= 16'd0;

            if (stall[0] && (stall_run == TO_LIMIT))
                stall_timeout <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= 32'd0;
        else if (stall[0])
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule
